// File: rtl/bk_save_ctrl.sv
// Backup-RAM save/load sequencer: turns load/save/format requests into SD sector runs.
// Build option: define BK_AUTOSAVE_EN to enable dirty tracking and autosave on OSD open.
//
// Ports:
//   clk_sys, reset            : clock, synchronous active-high reset
//   bk_ena                    : save image mounted and writable
//   load_req/save_req         : OSD load/save levels (rising edge triggers)
//   format_req                : OSD format level (rising edge triggers)
//   dl_active, img_nonzero    : cartridge download state, image size non-zero
//   osd_status, autosave      : OSD open, autosave option
//   bram_wr                   : core write strobe into backup RAM
//   sd_ack                    : HPS sector acknowledge
//   sd_lba, sd_rd, sd_wr      : sector number and read/write requests
//   busy, loading, pending    : run active, load active, unsaved writes exist
//   fmt_active/addr/data/we   : formatter ownership and write port to backup RAM
module bk_save_ctrl #(
    parameter int unsigned SECTORS = 16,
    parameter logic [15:0] FMT_W0  = 16'h5548,
    parameter logic [15:0] FMT_W1  = 16'h4D42,
    parameter logic [15:0] FMT_W2  = 16'h8800,
    parameter logic [15:0] FMT_W3  = 16'h8010
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        bk_ena,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        format_req,
    input  logic        dl_active,
    input  logic        img_nonzero,
    input  logic        osd_status,
    input  logic        autosave,
    input  logic        bram_wr,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        busy,
    output logic        loading,
    output logic        pending,
    output logic        fmt_active,
    output logic [1:0]  fmt_addr,
    output logic [15:0] fmt_data,
    output logic        fmt_we
);

    localparam int unsigned LW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam logic [LW-1:0] LAST = LW'(SECTORS - 1);
    localparam logic [LW-1:0] ONE  = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_FMT
    } state_t;

    state_t state_q, state_d;

    logic [LW-1:0] lba_q, lba_d;
    logic rd_q, rd_d;
    logic wr_q, wr_d;
    logic busy_q, busy_d;
    logic loading_q, loading_d;
    logic pending_q, pending_d;
    logic acked_q, acked_d;
    logic fmt_active_q, fmt_active_d;
    logic [1:0] fmt_addr_q, fmt_addr_d;
    logic [15:0] fmt_data_q, fmt_data_d;
    logic fmt_we_q, fmt_we_d;

    // Two-stage edge registers: stage 1 samples the input, stage 2 holds
    // the previous sample; edges are decoded from the registered pair.
    logic ld_r1_q, ld_r2_q;
    logic sv_r1_q, sv_r2_q;
    logic fm_r1_q, fm_r2_q;
    logic dl_r1_q, dl_r2_q;
    logic ak_r1_q, ak_r2_q;
    logic as_r1_q, as_r2_q;

    logic load_rise, save_rise, fmt_rise, dl_fall;
    logic ack_rise, ack_fall, as_rise, as_cond;
    logic save_trig;

`ifdef BK_AUTOSAVE_EN
    assign as_cond = pending_q & osd_status & autosave;
`else
    assign as_cond = 1'b0;
    logic unused_inputs;
    assign unused_inputs = &{1'b0, osd_status, autosave, bram_wr};
`endif

    assign load_rise = ld_r1_q & ~ld_r2_q;
    assign save_rise = sv_r1_q & ~sv_r2_q;
    assign fmt_rise  = fm_r1_q & ~fm_r2_q;
    assign dl_fall   = ~dl_r1_q & dl_r2_q;
    assign ack_rise  = ak_r1_q & ~ak_r2_q;
    assign ack_fall  = ~ak_r1_q & ak_r2_q;
    assign as_rise   = as_r1_q & ~as_r2_q;
    assign save_trig = save_rise | as_rise;

    always_comb begin
        state_d      = state_q;
        lba_d        = lba_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        busy_d       = busy_q;
        loading_d    = loading_q;
        acked_d      = acked_q;
        fmt_active_d = fmt_active_q;
        fmt_addr_d   = fmt_addr_q;
        fmt_we_d     = 1'b0;
        fmt_data_d   = 16'h0000;

        unique case (state_q)
            S_IDLE: begin
                if (fmt_rise) begin
                    state_d      = S_FMT;
                    fmt_active_d = 1'b1;
                    fmt_addr_d   = 2'd0;
                    fmt_we_d     = 1'b1;
                end else if ((dl_fall & img_nonzero & bk_ena)
                             | (load_rise & bk_ena)) begin
                    state_d   = S_XFER;
                    busy_d    = 1'b1;
                    loading_d = 1'b1;
                    lba_d     = '0;
                    rd_d      = 1'b1;
                    acked_d   = 1'b0;
                end else if (save_trig & bk_ena) begin
                    state_d   = S_XFER;
                    busy_d    = 1'b1;
                    loading_d = 1'b0;
                    lba_d     = '0;
                    wr_d      = 1'b1;
                    acked_d   = 1'b0;
                end
            end
            S_XFER: begin
                // A fall only counts once the current request was acked,
                // so a stale host ack after reset cannot advance the run.
                if (ack_rise & (rd_q | wr_q)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    acked_d = 1'b1;
                end else if (ack_fall & acked_q) begin
                    acked_d = 1'b0;
                    if (lba_q == LAST) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                    end else begin
                        lba_d = lba_q + ONE;
                        rd_d  = loading_q;
                        wr_d  = ~loading_q;
                    end
                end
            end
            S_FMT: begin
                if (fmt_addr_q == 2'd3) begin
                    state_d      = S_IDLE;
                    fmt_active_d = 1'b0;
                    fmt_addr_d   = 2'd0;
                end else begin
                    fmt_addr_d = fmt_addr_q + 2'd1;
                    fmt_we_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fmt_we_d) begin
            case (fmt_addr_d)
                2'd0:    fmt_data_d = FMT_W0;
                2'd1:    fmt_data_d = FMT_W1;
                2'd2:    fmt_data_d = FMT_W2;
                default: fmt_data_d = FMT_W3;
            endcase
        end

`ifdef BK_AUTOSAVE_EN
        // Any active run clears dirty state; writes only set it when idle.
        if (busy_q)
            pending_d = 1'b0;
        else if (bram_wr & bk_ena & ~osd_status)
            pending_d = 1'b1;
        else
            pending_d = pending_q;
`else
        pending_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lba_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            loading_q    <= 1'b0;
            pending_q    <= 1'b0;
            acked_q      <= 1'b0;
            fmt_active_q <= 1'b0;
            fmt_addr_q   <= 2'd0;
            fmt_data_q   <= 16'h0000;
            fmt_we_q     <= 1'b0;
            ld_r1_q      <= 1'b0;
            ld_r2_q      <= 1'b0;
            sv_r1_q      <= 1'b0;
            sv_r2_q      <= 1'b0;
            fm_r1_q      <= 1'b0;
            fm_r2_q      <= 1'b0;
            dl_r1_q      <= 1'b0;
            dl_r2_q      <= 1'b0;
            ak_r1_q      <= 1'b0;
            ak_r2_q      <= 1'b0;
            as_r1_q      <= 1'b0;
            as_r2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lba_q        <= lba_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            busy_q       <= busy_d;
            loading_q    <= loading_d;
            pending_q    <= pending_d;
            acked_q      <= acked_d;
            fmt_active_q <= fmt_active_d;
            fmt_addr_q   <= fmt_addr_d;
            fmt_data_q   <= fmt_data_d;
            fmt_we_q     <= fmt_we_d;
            ld_r1_q      <= load_req;
            ld_r2_q      <= ld_r1_q;
            sv_r1_q      <= save_req;
            sv_r2_q      <= sv_r1_q;
            fm_r1_q      <= format_req;
            fm_r2_q      <= fm_r1_q;
            dl_r1_q      <= dl_active;
            dl_r2_q      <= dl_r1_q;
            ak_r1_q      <= sd_ack;
            ak_r2_q      <= ak_r1_q;
            as_r1_q      <= as_cond;
            as_r2_q      <= as_r1_q;
        end
    end

    assign sd_lba     = {{(32 - LW){1'b0}}, lba_q};
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign busy       = busy_q;
    assign loading    = loading_q;
    assign pending    = pending_q;
    assign fmt_active = fmt_active_q;
    assign fmt_addr   = fmt_addr_q;
    assign fmt_data   = fmt_data_q;
    assign fmt_we     = fmt_we_q;

endmodule
